// File: rtl/keypad_scan_debouncer.sv
// Round-robin keypad scanner sharing one debounce counter across all key lines.
// Define KEYPAD_REPEAT_EN to add auto-repeat pulses while a key stays held.
module keypad_scan_debouncer #(
    parameter int NUM_KEYS      = 10,
    parameter int CODE_W        = 4,
    parameter int DEB_CYCLES    = 7,
    parameter int REL_CYCLES    = 7,
    parameter int REPEAT_CYCLES = 200
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] keys_in,
    input  logic                enable,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    output logic                busy
);

    localparam int CNT_A   = (DEB_CYCLES > REL_CYCLES) ? DEB_CYCLES : REL_CYCLES;
    localparam int CNT_MAX = (CNT_A > REPEAT_CYCLES) ? CNT_A : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CODE_W-1:0] LAST_KEY = CODE_W'(NUM_KEYS - 1);
    localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0]  REL_LAST = CNT_W'(REL_CYCLES - 1);
`ifdef KEYPAD_REPEAT_EN
    localparam logic [CNT_W-1:0]  REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HELD  = 2'd2,
        REL   = 2'd3
    } state_t;

    state_t              state;
    logic [NUM_KEYS-1:0] sync_meta;
    logic [NUM_KEYS-1:0] keys_s;
    logic [CODE_W-1:0]   ptr;
    logic [CODE_W-1:0]   sel;
    logic [CODE_W-1:0]   ptr_inc;
    logic [CODE_W-1:0]   sel_inc;
    logic [CNT_W-1:0]    cnt;

    // Two-flop synchroniser; keys_in is asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            keys_s    <= '0;
        end else begin
            sync_meta <= keys_in;
            keys_s    <= sync_meta;
        end
    end

    assign ptr_inc = (ptr == LAST_KEY) ? '0 : ptr + 1'b1;
    assign sel_inc = (sel == LAST_KEY) ? '0 : sel + 1'b1;

    // Resuming the scan at sel+1 keeps service fair among simultaneous presses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            sel       <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        if (keys_s[ptr]) begin
                            sel   <= ptr;
                            cnt   <= '0;
                            state <= PRESS;
                            busy  <= 1'b1;
                        end else begin
                            ptr <= ptr_inc;
                        end
                    end
                end
                PRESS: begin
                    if (!keys_s[sel] || !enable) begin
                        ptr   <= sel_inc;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == DEB_LAST) begin
                        key_code  <= sel;
                        key_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= HELD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!keys_s[sel]) begin
                        cnt   <= '0;
                        state <= REL;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (cnt == REP_LAST) begin
                        key_code  <= sel;
                        key_valid <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                REL: begin
                    if (keys_s[sel]) begin
                        cnt   <= '0;
                        state <= HELD;
                    end else if (cnt == REL_LAST) begin
                        ptr   <= sel_inc;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_debouncer.sv
// Randomised bench for keypad_scan_debouncer against a behavioural model of the
// scan / debounce / release rules; define KEYPAD_REPEAT_EN to exercise auto-repeat.
module tb_keypad_scan_debouncer;

    localparam int NK  = 10;
    localparam int CW  = 4;
    localparam int DEB = 7;
    localparam int REL = 7;
`ifdef KEYPAD_REPEAT_EN
    localparam int REP = 20;
`else
    localparam int REP = 200;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] keys_in = '0;
    logic          enable = 1'b0;
    logic [CW-1:0] key_code;
    logic          key_valid;
    logic          busy;

    keypad_scan_debouncer #(
        .NUM_KEYS(NK), .CODE_W(CW), .DEB_CYCLES(DEB),
        .REL_CYCLES(REL), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .keys_in(keys_in), .enable(enable),
        .key_code(key_code), .key_valid(key_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Behavioural model: phase 0 scanning, 1 confirming press, 2 held,
    // 3 confirming release; run = consecutive stable edges in the phase.
    int            m_phase, m_scan, m_lock, m_run, m_pulses;
    logic [NK-1:0] m_s1, m_s2;
    logic          exp_valid, exp_busy;
    logic [CW-1:0] exp_code;

    int       bad = 0;
    int       bad_cyc;
    logic [5:0] bad_act, bad_exp;
    int       pulse_q[$];
    int       pulse_cyc[$];

    task automatic model_reset();
        m_phase = 0; m_scan = 0; m_lock = 0; m_run = 0;
        m_s1 = '0; m_s2 = '0;
        exp_valid = 1'b0; exp_busy = 1'b0; exp_code = '0;
    endtask

    task automatic model_edge();
        logic [NK-1:0] ks;
        ks = m_s2;
        exp_valid = 1'b0;
        case (m_phase)
            0: if (enable) begin
                if (ks[m_scan]) begin
                    m_lock = m_scan; m_run = 0; m_phase = 1;
                end else begin
                    m_scan = (m_scan + 1) % NK;
                end
            end
            1: if (!ks[m_lock] || !enable) begin
                m_phase = 0; m_scan = (m_lock + 1) % NK;
            end else begin
                m_run++;
                if (m_run == DEB) begin
                    exp_valid = 1'b1; exp_code = CW'(m_lock);
                    m_pulses++; m_run = 0; m_phase = 2;
                end
            end
            2: if (!ks[m_lock]) begin
                m_phase = 3; m_run = 0;
            end
`ifdef KEYPAD_REPEAT_EN
            else begin
                m_run++;
                if (m_run == REP) begin
                    exp_valid = 1'b1; exp_code = CW'(m_lock);
                    m_pulses++; m_run = 0;
                end
            end
`endif
            default: if (ks[m_lock]) begin
                m_phase = 2; m_run = 0;
            end else begin
                m_run++;
                if (m_run == REL) begin
                    m_phase = 0; m_scan = (m_lock + 1) % NK;
                end
            end
        endcase
        m_s2 = m_s1;
        m_s1 = keys_in;
        exp_busy = (m_phase != 0);
    endtask

    // Advance one clock, update the model and log any divergence for the caller.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (key_valid === 1'b1) begin
            pulse_q.push_back(int'(key_code));
            pulse_cyc.push_back(cyc);
            $display("pulse code=%0d cycle=%0d", key_code, cyc);
        end
        if ({key_valid, key_code, busy} !== {exp_valid, exp_code, exp_busy}) begin
            if (bad == 0) begin
                bad_cyc = cyc;
                bad_act = {key_valid, key_code, busy};
                bad_exp = {exp_valid, exp_code, exp_busy};
            end
            bad++;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_log();
        pulse_q.delete();
        pulse_cyc.delete();
        bad = 0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (4) begin
            keys_in = NK'($urandom);
            enable  = 1'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if (key_code !== 4'd0 || key_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_values actual code=%0d valid=%b busy=%b required 0/0/0",
                         key_code, key_valid, busy);
            end
        end
        keys_in = '0;
        enable  = 1'b1;
        rst_n   = 1'b1;
        clear_log();
        run(50);
        checks++;
        if (pulse_q.size() !== 0) begin
            errors++;
            $display("FAIL reset_idle_pulses actual=%0d required=0", pulse_q.size());
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_idle_trace cycle=%0d actual=%h required=%h", bad_cyc, bad_act, bad_exp);
        end
    endtask

    task automatic test_single_press();
        int t0, got, lat;
        clear_log();
        run(5);
        t0 = cyc;
        keys_in = '0; keys_in[5] = 1'b1;
        run(40);
        keys_in = '0;
        run(30);
        got = (pulse_q.size() > 0) ? pulse_q[0] : -1;
        lat = (pulse_q.size() > 0) ? pulse_cyc[0] - t0 + 1 : 999;
        checks++;
        if (pulse_q.size() !== 1 || got !== 5) begin
            errors++;
            $display("FAIL single_press actual count=%0d code=%0d required count=1 code=5", pulse_q.size(), got);
        end
        checks++;
        if (lat > 2 + NK + DEB) begin
            errors++;
            $display("FAIL single_latency actual=%0d required<=%0d", lat, 2 + NK + DEB);
        end
        checks++;
        if (bad !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_trace cycle=%0d actual=%h required=%h busy=%b", bad_cyc, bad_act, bad_exp, busy);
        end
    endtask

    task automatic test_short_press();
        int got;
        clear_log();
        keys_in = '0; keys_in[3] = 1'b1;
        run(4);
        keys_in = '0;
        run(20);
        checks++;
        if (pulse_q.size() !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL short_glitch actual count=%0d busy=%b required count=0 busy=0", pulse_q.size(), busy);
        end
        keys_in[3] = 1'b1;
        run(20);
        keys_in = '0;
        run(30);
        got = (pulse_q.size() > 0) ? pulse_q[0] : -1;
        checks++;
        if (pulse_q.size() !== 1 || got !== 3) begin
            errors++;
            $display("FAIL short_then_long actual count=%0d code=%0d required count=1 code=3", pulse_q.size(), got);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL short_trace cycle=%0d actual=%h required=%h", bad_cyc, bad_act, bad_exp);
        end
    endtask

    task automatic test_simultaneous();
        int c0, c1;
        do_reset();
        clear_log();
        keys_in = '0; keys_in[2] = 1'b1; keys_in[7] = 1'b1;
        run(60);
        keys_in[2] = 1'b0;
        run(40);
        keys_in = '0;
        run(30);
        c0 = (pulse_q.size() > 0) ? pulse_q[0] : -1;
        c1 = (pulse_q.size() > 1) ? pulse_q[1] : -1;
        checks++;
        if (pulse_q.size() !== 2 || c0 !== 2 || c1 !== 7) begin
            errors++;
            $display("FAIL simultaneous actual count=%0d codes=%0d,%0d required count=2 codes=2,7",
                     pulse_q.size(), c0, c1);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL simultaneous_trace cycle=%0d actual=%h required=%h", bad_cyc, bad_act, bad_exp);
        end
    endtask

    task automatic test_release_bounce();
        int c0, c1;
        clear_log();
        keys_in = '0; keys_in[9] = 1'b1;
        run(30);
        keys_in = '0;           run(3);
        keys_in[9] = 1'b1;      run(2);
        keys_in = '0;           run(20);
        keys_in[0] = 1'b1;      run(25);
        keys_in = '0;           run(20);
        c0 = (pulse_q.size() > 0) ? pulse_q[0] : -1;
        c1 = (pulse_q.size() > 1) ? pulse_q[1] : -1;
        checks++;
        if (pulse_q.size() !== 2 || c0 !== 9 || c1 !== 0) begin
            errors++;
            $display("FAIL release_bounce actual count=%0d codes=%0d,%0d required count=2 codes=9,0",
                     pulse_q.size(), c0, c1);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bounce_trace cycle=%0d actual=%h required=%h", bad_cyc, bad_act, bad_exp);
        end
    endtask

    task automatic test_reset_mid_press();
        int n;
        do_reset();
        clear_log();
        keys_in = '0; keys_in[4] = 1'b1;
        n = 0;
        while (!(m_phase == 1 && m_run == 4) && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (n >= 40 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_press_reach actual steps=%0d busy=%b required steps<40 busy=1", n, busy);
        end
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (key_code !== 4'd0 || key_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_press_reset actual code=%0d valid=%b busy=%b required 0/0/0",
                     key_code, key_valid, busy);
        end
        keys_in = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        run(20);
        checks++;
        if (pulse_q.size() !== 0 || bad !== 0) begin
            errors++;
            $display("FAIL mid_press_after actual pulses=%0d bad=%0d required 0/0", pulse_q.size(), bad);
        end
    endtask

    task automatic test_random();
        int hold, gap, k, start_pulses;
        for (int t = 0; t < 40; t++) begin
            clear_log();
            start_pulses = m_pulses;
            k = $urandom_range(0, NK - 1);
            keys_in = '0;
            keys_in[k] = 1'b1;
            if ($urandom_range(0, 3) == 0) keys_in[$urandom_range(0, NK - 1)] = 1'b1;
            enable = ($urandom_range(0, 7) != 0);
            hold = $urandom_range(1, 40);
            gap  = $urandom_range(0, 25);
            $display("txn %0d keys=%h en=%b hold=%0d gap=%0d", t, keys_in, enable, hold, gap);
            run(hold);
            if ($urandom_range(0, 4) == 0) begin
                keys_in = '0; run($urandom_range(1, 4));
                keys_in[k] = 1'b1; run($urandom_range(1, 10));
            end
            keys_in = '0;
            run(gap);
            enable = 1'b1;
            checks++;
            if (bad !== 0 || pulse_q.size() !== m_pulses - start_pulses) begin
                errors++;
                $display("FAIL random_txn_%0d cycle=%0d actual=%h required=%h pulses=%0d expected=%0d",
                         t, bad_cyc, bad_act, bad_exp, pulse_q.size(), m_pulses - start_pulses);
            end
        end
        keys_in = '0;
        run(40);
    endtask

`ifdef KEYPAD_REPEAT_EN
    task automatic test_repeat();
        int wrong;
        do_reset();
        clear_log();
        m_pulses = 0;
        keys_in = '0; keys_in[1] = 1'b1;
        run(100);
        keys_in = '0;
        run(30);
        wrong = 0;
        foreach (pulse_q[i]) if (pulse_q[i] != 1) wrong++;
        checks++;
        if (pulse_q.size() < 4 || wrong != 0 || pulse_q.size() != m_pulses || bad !== 0) begin
            errors++;
            $display("FAIL repeat actual count=%0d wrong=%0d bad=%0d required count=%0d wrong=0 bad=0",
                     pulse_q.size(), wrong, bad, m_pulses);
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_pulses = 0;
        model_reset();
        test_reset();
        test_single_press();
        test_short_press();
        test_simultaneous();
        test_release_bounce();
        test_reset_mid_press();
        test_random();
`ifdef KEYPAD_REPEAT_EN
        test_repeat();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
